// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared definitions for the bit-serial arithmetic blocks:
//                controller state encoding, default operand width and a
//                ceiling-log2 helper used to size bit counters.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

   // Controller states. Encoding 2'd3 is unused and decodes back to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int c_default_width = 8;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/subtractor_component.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_component
//  Description : Combinational one-bit full subtractor (A - B - borrow_in).
//  Ports       : A, B       - operand bits
//                borrow_in  - borrow from the less significant bit
//                D          - difference bit
//                borrow_out - borrow into the more significant bit
//  Revision    : 1.0 - initial release
// ============================================================================
module subtractor_component (
   input  logic A,
   input  logic B,
   input  logic borrow_in,
   output logic D,
   output logic borrow_out
);

   assign D          = A ^ B ^ borrow_in;
   // Borrow when B exceeds A outright, or when they are equal and a borrow
   // is already pending from below.
   assign borrow_out = (~A & B) | (~(A ^ B) & borrow_in);

endmodule : subtractor_component
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor, D = A - B mod 2^WIDTH,
//                processed LSB first over WIDTH cycles with a single
//                full-subtractor cell and one borrow flop.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                in_valid / in_ready  - operand handshake (A, B)
//                out_valid / out_ready- result handshake (D, borrow_out)
//                A, B, D              - [0:WIDTH-1], index 0 = MSB
//                borrow_out           - 1 when A < B (unsigned)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:WIDTH-1] A,
   input  logic [0:WIDTH-1] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:WIDTH-1] D,
   output logic             borrow_out
);

   // One extra bit so the counter can hold WIDTH without wrapping.
   localparam int c_cnt_w = clog2(WIDTH) + 1;

   state_t             r_state;
   state_t             w_state_next;
   logic [0:WIDTH-1]   r_a;
   logic [0:WIDTH-1]   r_b;
   logic [0:WIDTH-1]   r_d;
   logic               r_borrow;
   logic               r_borrow_out;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_idx;
   logic               w_last;
   logic               w_diff_bit;
   logic               w_borrow_bit;

   // The operand registers shift toward higher indices, so the bit under
   // process always sits at index WIDTH-1.
   subtractor_component u_cell (
      .A          (r_a[WIDTH-1]),
      .B          (r_b[WIDTH-1]),
      .borrow_in  (r_borrow),
      .D          (w_diff_bit),
      .borrow_out (w_borrow_bit)
   );

   assign w_last = (r_cnt == c_cnt_w'(WIDTH - 1));
   assign w_idx  = c_cnt_w'(WIDTH - 1) - r_cnt;

   // ---------------------------------------------------------------- FSM --
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid && in_ready) w_state_next = RUN;
         RUN:     if (w_last)               w_state_next = DONE;
         DONE:    if (out_ready)            w_state_next = IDLE;
         default:                           w_state_next = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath --
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a          <= '0;
         r_b          <= '0;
         r_d          <= '0;
         r_borrow     <= 1'b0;
         r_borrow_out <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= A;
                  r_b      <= B;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               r_a      <= {1'b0, r_a[0:WIDTH-2]};
               r_b      <= {1'b0, r_b[0:WIDTH-2]};
               r_borrow <= w_borrow_bit;
               r_cnt    <= r_cnt + c_cnt_w'(1);
               // Result bit lands at the same index its operands came from.
               for (int i = 0; i < WIDTH; i++) begin
                  if (w_idx == c_cnt_w'(i)) begin
                     r_d[i] <= w_diff_bit;
                  end
               end
               if (w_last) begin
                  r_borrow_out <= w_borrow_bit;
               end
            end
            default: begin
               // DONE and the illegal encoding hold the result.
            end
         endcase
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = (r_state == DONE);
   assign D          = r_d;
   assign borrow_out = r_borrow_out;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor. Expected results
//                come from plain (WIDTH+1)-bit unsigned subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [0:WIDTH-1] A;
   logic [0:WIDTH-1] B;
   logic             out_valid;
   logic             out_ready;
   logic [0:WIDTH-1] D;
   logic             borrow_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .D          (D),
      .borrow_out (borrow_out)
   );

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, wait for result, optional stall, handshake.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int stall, input bit hold_valid);
      logic [WIDTH:0] exp;
      int             cyc;
      int             bad_ready;
      exp = {1'b0, a} - {1'b0, b};
      check_value("ready_before", 32'(in_ready), 32'd1);
      A         = a;
      B         = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      if (!hold_valid) in_valid = 1'b0;
      cyc       = 0;
      bad_ready = 0;
      while (!out_valid && cyc < 4 * WIDTH) begin
         if (in_ready) bad_ready++;
         if (hold_valid) begin
            A = WIDTH'($urandom);
            B = WIDTH'($urandom);
         end
         tick();
         cyc++;
      end
      if (in_ready) bad_ready++;
      check_value("latency", 32'(cyc), 32'(WIDTH));
      check_value("diff", 32'(D), 32'(exp[WIDTH-1:0]));
      check_value("borrow", 32'(borrow_out), 32'(exp[WIDTH]));
      for (int s = 0; s < stall; s++) begin
         if (hold_valid) begin
            A = WIDTH'($urandom);
            B = WIDTH'($urandom);
         end
         tick();
         if (in_ready) bad_ready++;
         check_value("stall_valid", 32'(out_valid), 32'd1);
         check_value("stall_diff", 32'({borrow_out, D}), 32'(exp));
      end
      check_value("ready_low_during_op", 32'(bad_ready), 32'd0);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      tick();
      out_ready = 1'b0;
      check_value("valid_after_hs", 32'(out_valid), 32'd0);
      check_value("ready_after_hs", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      tick();
      tick();
      rst = 1'b0;
      check_value("rst_in_ready", 32'(in_ready), 32'd1);
      check_value("rst_out_valid", 32'(out_valid), 32'd0);
      check_value("rst_d", 32'(D), 32'd0);
      check_value("rst_borrow", 32'(borrow_out), 32'd0);

      // Directed cases, including equal operands and the full-scale borrow.
      run_op(8'h02, 8'h02, 0, 1'b0);
      run_op(8'h01, 8'h03, 0, 1'b0);
      run_op(8'h92, 8'hAB, 0, 1'b0);
      run_op(8'hFF, 8'h01, 0, 1'b0);
      run_op(8'h00, 8'hFF, 0, 1'b0);
      run_op(8'h10, 8'h01, 5, 1'b0);
      run_op(8'h3C, 8'h7E, 3, 1'b1);

      // Reset on the third RUN edge aborts the operation.
      A        = 8'h55;
      B        = 8'hAA;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_value("abort_in_ready", 32'(in_ready), 32'd1);
      check_value("abort_out_valid", 32'(out_valid), 32'd0);
      check_value("abort_borrow", 32'(borrow_out), 32'd0);
      check_value("abort_d", 32'(D), 32'd0);
      run_op(8'h05, 8'h03, 0, 1'b0);

      // Random sweep with random output stalls.
      for (int n = 0; n < 1000; n++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_serial_subtractor
`default_nettype wire
